// File: rtl/sram_rd_arbiter.sv
// rtl/sram_rd_arbiter.sv - round-robin read scheduler for a 16-requester shared SRAM bank
//
// Purpose:
//   Picks at most one read requester per cycle, round-robin from a rotating
//   pointer. It drives the port-mux select/enable and tags each access with
//   its requester ID. After RD_LAT+1 cycles it returns the SRAM read data to
//   that requester with a one-cycle valid strobe.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   req       per-requester read request (level, held until granted)
//   mem_hold  blocks new grants; reads already in flight still complete
//   sram_q    SRAM read data
//   sel_out   registered mux select
//   mem_en    registered access enable (1 = read access this cycle)
//   gnt       registered one-hot grant, high during the access cycle
//   rvalid    read-data valid strobe
//   rid       requester ID belonging to rdata (meaningful when rvalid=1)
//   rdata     registered SRAM read data, held while rvalid=0

`ifndef D_width
`define D_width 32
`endif

module sram_rd_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int SEL_W   = 4,
    parameter int RD_LAT  = 1,
    parameter int DW      = `D_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mem_hold,
    input  logic [DW-1:0]      sram_q,
    output logic [SEL_W-1:0]   sel_out,
    output logic               mem_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rvalid,
    output logic [SEL_W-1:0]   rid,
    output logic [DW-1:0]      rdata
);

    // Arbitration state
    logic [SEL_W-1:0]   ptr_q,  ptr_d;
    logic [SEL_W-1:0]   sel_q,  sel_d;
    logic               en_q,   en_d;
    logic [NUM_REQ-1:0] gnt_q,  gnt_d;

    // Tag pipeline: stage k holds the access issued k+1 cycles ago
    logic [RD_LAT-1:0]  tag_v_q;
    logic [SEL_W-1:0]   tag_id_q [RD_LAT];

    // Read-return registers
    logic               rvalid_q;
    logic [SEL_W-1:0]   rid_q;
    logic [DW-1:0]      rdata_q;

    // Search state
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [SEL_W-1:0]   win;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W:0]     ptr_sum;

    // Winner search: first eligible requester at or above ptr, wrapping.
    // The requester holding the grant this cycle is masked so that a
    // requester that keeps req high through its access cycle is not
    // granted twice in a row.
    always_comb begin
        eligible = req & ~gnt_q;
        found    = 1'b0;
        win      = ptr_q;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + SEL_W'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        en_d    = 1'b0;
        gnt_d   = '0;
        ptr_sum = {1'b0, win} + {{SEL_W{1'b0}}, 1'b1};
        if (!mem_hold && found) begin
            sel_d = win;
            gnt_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            en_d  = 1'b1;
            ptr_d = ptr_sum[SEL_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            sel_q <= '0;
            en_q  <= 1'b0;
            gnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            sel_q <= sel_d;
            en_q  <= en_d;
            gnt_q <= gnt_d;
        end
    end

    // Tag pipeline. Only the valid bits need clearing on reset; once they
    // are cleared, in-flight accesses never produce an rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q[0]  <= en_q;
            tag_id_q[0] <= sel_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // Read return: Q is valid in the cycle the last tag stage is occupied.
    // rdata/rid only load on a valid tag, so they hold between returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= tag_v_q[RD_LAT-1];
            if (tag_v_q[RD_LAT-1]) begin
                rid_q   <= tag_id_q[RD_LAT-1];
                rdata_q <= sram_q;
            end
        end
    end

    assign sel_out = sel_q;
    assign mem_en  = en_q;
    assign gnt     = gnt_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// tb/tb_sram_rd_arbiter.sv - self-checking bench for sram_rd_arbiter (RD_LAT=1 and RD_LAT=3)

module tb_sram_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        mem_hold;
    logic [31:0] sram_q1, sram_q3;

    logic [3:0]  sel1, sel3, rid1, rid3;
    logic        en1, en3, rv1, rv3;
    logic [15:0] gnt1, gnt3;
    logic [31:0] rd1, rd3;

    int n_chk = 0;
    int n_err = 0;
    bit directed = 1'b1;

    always #5 clk = ~clk;

    sram_rd_arbiter #(.NUM_REQ(16), .SEL_W(4), .RD_LAT(1), .DW(32)) u_d1 (
        .clk(clk), .rst(rst), .req(req), .mem_hold(mem_hold), .sram_q(sram_q1),
        .sel_out(sel1), .mem_en(en1), .gnt(gnt1), .rvalid(rv1), .rid(rid1), .rdata(rd1)
    );

    sram_rd_arbiter #(.NUM_REQ(16), .SEL_W(4), .RD_LAT(3), .DW(32)) u_d3 (
        .clk(clk), .rst(rst), .req(req), .mem_hold(mem_hold), .sram_q(sram_q3),
        .sel_out(sel3), .mem_en(en3), .gnt(gnt3), .rvalid(rv3), .rid(rid3), .rdata(rd3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycle number cyc names the clock period that follows the cyc-th edge.
    // Accesses are logged per cycle; a read issued in cycle c returns in
    // cycle c+L+1. A reset wipes the log, so pre-reset reads never return.
    int          cyc = 100;
    int          m_ptr = 0;
    logic [3:0]  m_sel = '0;
    logic        m_en = 1'b0;
    logic [15:0] m_gnt = '0;
    bit          a_en  [64];
    logic [3:0]  a_id  [64];
    logic [31:0] a_dat [64];
    int          lat   [2] = '{1, 3};
    bit          e_rv  [2];
    logic [3:0]  e_rid [2];
    logic [31:0] e_rd  [2];

    always @(posedge clk or posedge rst) begin
        int          slot;
        int          win;
        int          r;
        logic [15:0] elig;
        if (rst) begin
            m_ptr = 0;
            m_sel = '0;
            m_en  = 1'b0;
            m_gnt = '0;
            for (int i = 0; i < 64; i++) a_en[i] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                e_rv[j] = 1'b0; e_rid[j] = '0; e_rd[j] = '0;
            end
        end else begin
            cyc++;
            slot = (cyc - 1) & 63;
            a_en[slot]  = m_en;
            a_id[slot]  = m_sel;
            a_dat[slot] = directed ? {16'hA5A5, 12'h000, m_sel} : $urandom;
            elig = req & ~m_gnt;
            win  = -1;
            if (!mem_hold) begin
                for (int k = 0; k < 16; k++)
                    if (win < 0 && elig[(m_ptr + k) % 16]) win = (m_ptr + k) % 16;
            end
            if (win >= 0) begin
                m_sel = win[3:0];
                m_gnt = 16'h0001 << win;
                m_en  = 1'b1;
                m_ptr = (win + 1) % 16;
            end else begin
                m_en  = 1'b0;
                m_gnt = '0;
            end
            for (int j = 0; j < 2; j++) begin
                r = (cyc - lat[j] - 1) & 63;
                e_rv[j] = a_en[r];
                if (a_en[r]) begin
                    e_rid[j] = a_id[r];
                    e_rd[j]  = a_dat[r];
                end
            end
        end
    end

    // SRAM: Q in cycle t carries the data of the access made in cycle t-L,
    // junk otherwise.
    always @(posedge clk or posedge rst) begin
        int r1, r3;
        #1;
        r1 = (cyc - 1) & 63;
        r3 = (cyc - 3) & 63;
        sram_q1 = a_en[r1] ? a_dat[r1] : $urandom;
        sram_q3 = a_en[r3] ? a_dat[r3] : $urandom;
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(posedge clk);
        #4;
        chk("d1.mem_en",  {31'b0, en1},  {31'b0, m_en});
        chk("d1.gnt",     {16'b0, gnt1}, {16'b0, m_gnt});
        chk("d1.sel_out", {28'b0, sel1}, {28'b0, m_sel});
        chk("d1.rvalid",  {31'b0, rv1},  {31'b0, e_rv[0]});
        chk("d1.rdata",   rd1,           e_rd[0]);
        if (e_rv[0]) chk("d1.rid", {28'b0, rid1}, {28'b0, e_rid[0]});
        chk("d3.mem_en",  {31'b0, en3},  {31'b0, m_en});
        chk("d3.gnt",     {16'b0, gnt3}, {16'b0, m_gnt});
        chk("d3.sel_out", {28'b0, sel3}, {28'b0, m_sel});
        chk("d3.rvalid",  {31'b0, rv3},  {31'b0, e_rv[1]});
        chk("d3.rdata",   rd3,           e_rd[1]);
        if (e_rv[1]) chk("d3.rid", {28'b0, rid3}, {28'b0, e_rid[1]});
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; mem_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt [16];

    initial begin
        rst = 1'b1; req = '0; mem_hold = 1'b0;
        repeat (3) @(negedge clk);

        // Reset release with all requesting, then round-robin fairness
        rst = 1'b0; req = 16'hFFFF;
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        @(negedge clk);
        chk("first.gnt", {16'b0, gnt1}, 32'h0000_0001);
        chk("first.sel", {28'b0, sel1}, 32'h0);
        chk("first.en",  {31'b0, en1},  32'h1);
        cnt[sel1]++;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            chk("rr.sel", {28'b0, sel1}, i % 16);
            chk("rr.en",  {31'b0, en1}, 32'h1);
            cnt[sel1]++;
        end
        for (int i = 0; i < 16; i++) chk("rr.count", cnt[i], 32'd2);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.outs1", {sel1, en1, gnt1, rv1, rid1}, 32'h0);
        chk("arst.outs3", {sel3, en3, gnt3, rv3, rid3}, 32'h0);
        chk("arst.rd1", rd1, 32'h0);
        chk("arst.rd3", rd3, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.regrant", {16'b0, gnt1}, 32'h0000_0001);

        // Wrap and skip
        do_reset();
        req = 16'h2000;
        @(negedge clk); chk("wrap.g13", {16'b0, gnt1}, 32'h2000);
        req = 16'h0000;
        @(negedge clk);
        req = 16'h4001;
        @(negedge clk); chk("wrap.g14a", {16'b0, gnt1}, 32'h4000);
        @(negedge clk); chk("wrap.g0",   {16'b0, gnt1}, 32'h0001);
        @(negedge clk); chk("wrap.g14b", {16'b0, gnt1}, 32'h4000);
        req = 16'h0008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("skip.g3", {16'b0, gnt1}, (i % 2 == 0) ? 32'h0008 : 32'h0);
        end
        req = '0;

        // Latency, RD_LAT=1 and RD_LAT=3
        do_reset();
        req = 16'h0020;
        @(negedge clk); chk("lat.gnt5", {16'b0, gnt1}, 32'h0020);
        req = '0;
        @(negedge clk); chk("lat1.early", {31'b0, rv1}, 32'h0);
        @(negedge clk);
        chk("lat1.rvalid", {31'b0, rv1}, 32'h1);
        chk("lat1.rid",    {28'b0, rid1}, 32'h5);
        chk("lat1.rdata",  rd1, 32'hA5A5_0005);
        @(negedge clk);
        chk("lat1.pulse", {31'b0, rv1}, 32'h0);
        chk("lat3.early", {31'b0, rv3}, 32'h0);
        @(negedge clk);
        chk("lat3.rvalid", {31'b0, rv3}, 32'h1);
        chk("lat3.rid",    {28'b0, rid3}, 32'h5);
        chk("lat3.rdata",  rd3, 32'hA5A5_0005);

        // Hold
        do_reset();
        req = 16'h0003;
        @(negedge clk); chk("hold.g0", {16'b0, gnt1}, 32'h0001);
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold.en", {31'b0, en1}, 32'h0);
            if (i == 1) chk("hold.rv1", {31'b0, rv1}, 32'h1);
            if (i == 3) chk("hold.rv3", {31'b0, rv3}, 32'h1);
        end
        mem_hold = 1'b0;
        @(negedge clk); chk("hold.resume", {16'b0, gnt1}, 32'h0002);
        req = '0;

        // Reset while a read is in flight
        do_reset();
        req = 16'h0080;
        @(negedge clk); chk("flight.g7", {16'b0, gnt1}, 32'h0080);
        req = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flight.rv1", {31'b0, rv1}, 32'h0);
            chk("flight.rv3", {31'b0, rv3}, 32'h0);
        end

        // Randomized traffic
        directed = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom % 100) == 0;
            mem_hold = ($urandom % 8) == 0;
            case ($urandom % 4)
                0: req = 16'($urandom);
                1: req = 16'h0001 << ($urandom % 16);
                2: req = 16'hFFFF;
                default: req = 16'($urandom) & 16'($urandom);
            endcase
        end
        rst = 1'b0; req = '0; mem_hold = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
